// File: rtl/alu_result_serializer_pkg.sv
// Shared types and sizing helpers for the ALU result serializer.
package alu_result_serializer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam int unsigned BYTE_W = 8;

   function automatic int unsigned num_bytes(input int unsigned width);
      return width / BYTE_W;
   endfunction

   // Byte index needs at least one bit even for single-byte results.
   function automatic int unsigned idx_width(input int unsigned nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/alu_result_serializer_result_fifo.sv
// WIDTH x DEPTH synchronous FIFO holding captured ALU results.
module result_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_c,
   output logic             full_c,
   output logic             empty_c
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   always_comb begin
      empty_c  = (wr_ptr_q == rd_ptr_q);
      full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = pop_i && !empty_c;
      do_push  = push_i && (!full_c || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
      dout_c   = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
         end
      end
   end

endmodule

// File: rtl/alu_result_serializer.sv
// Captures ALU results into a FIFO and streams them out LSB byte first over valid/ready.
module alu_result_serializer
   import alu_result_serializer_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] RES_DATA,
   input  logic             RES_VALID,
   input  logic             TX_READY,
   output logic [7:0]       TX_DATA,
   output logic             TX_VALID,
   output logic             BUSY,
   output logic             DROP
);

   localparam int unsigned NB = num_bytes(WIDTH);
   localparam int unsigned IW = idx_width(NB);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             tx_valid_q, tx_valid_d;
   logic             drop_q, drop_d;
   logic             fifo_pop;
   logic [WIDTH-1:0] fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;

   result_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_result_fifo (
      .clk     (CLK),
      .rst_n   (RST),
      .push_i  (RES_VALID),
      .din_i   (RES_DATA),
      .pop_i   (fifo_pop),
      .dout_c  (fifo_dout),
      .full_c  (fifo_full),
      .empty_c (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      idx_d      = idx_q;
      tx_valid_d = tx_valid_q;
      fifo_pop   = 1'b0;
      case (state_q)
         IDLE: begin
            tx_valid_d = 1'b0;
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shreg_d    = fifo_dout;
               idx_d      = '0;
               tx_valid_d = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (tx_valid_q && TX_READY) begin
               if (idx_q != IW'(NB - 1)) begin
                  shreg_d = shreg_q >> BYTE_W;
                  idx_d   = idx_q + IW'(1);
               end else if (!fifo_empty) begin
                  // Chain straight into the next word without an idle bubble.
                  fifo_pop = 1'b1;
                  shreg_d  = fifo_dout;
                  idx_d    = '0;
               end else begin
                  tx_valid_d = 1'b0;
                  state_d    = IDLE;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
         end
      endcase
      // A pop at the same edge frees the slot, so a full FIFO still accepts the push.
      drop_d = RES_VALID && fifo_full && !fifo_pop;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         idx_q      <= '0;
         tx_valid_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         idx_q      <= idx_d;
         tx_valid_q <= tx_valid_d;
         drop_q     <= drop_d;
      end
   end

   assign TX_DATA  = shreg_q[BYTE_W-1:0];
   assign TX_VALID = tx_valid_q;
   assign DROP     = drop_q;
   assign BUSY     = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench for alu_result_serializer: directed scenarios plus a randomized model run.
module tb_alu_result_serializer;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned NB    = WIDTH / 8;

   logic             CLK = 1'b0;
   logic             RST;
   logic [WIDTH-1:0] RES_DATA;
   logic             RES_VALID;
   logic             TX_READY;
   logic [7:0]       TX_DATA;
   logic             TX_VALID;
   logic             BUSY;
   logic             DROP;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   alu_result_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RES_DATA  (RES_DATA),
      .RES_VALID (RES_VALID),
      .TX_READY  (TX_READY),
      .TX_DATA   (TX_DATA),
      .TX_VALID  (TX_VALID),
      .BUSY      (BUSY),
      .DROP      (DROP)
   );

   always #5 CLK = ~CLK;

   // Reference model: queue of waiting words plus the bytes still owed for the word on the link.
   logic [WIDTH-1:0] m_fifo [$];
   logic [7:0]       m_cur  [$];
   logic             m_drop;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         m_fifo.delete();
         m_cur.delete();
         m_drop = 1'b0;
      end else begin
         bit               xfer;
         bit               take;
         logic [WIDTH-1:0] w;
         xfer   = (m_cur.size() > 0) && TX_READY;
         take   = (m_fifo.size() > 0) && ((m_cur.size() == 0) || (xfer && m_cur.size() == 1));
         m_drop = RES_VALID && (m_fifo.size() == DEPTH) && !take;
         if (xfer) void'(m_cur.pop_front());
         if (take) begin
            w = m_fifo.pop_front();
            for (int b = 0; b < NB; b++) m_cur.push_back(w[8*b +: 8]);
         end
         if (RES_VALID && !m_drop) m_fifo.push_back(RES_DATA);
      end
   end

   task automatic test_reset();
      RST = 1'b0; RES_VALID = 1'b0; TX_READY = 1'b0; RES_DATA = '0;
      repeat (3) @(negedge CLK);
      n_checks++; if (TX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", TX_DATA); end
      n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", TX_VALID); end
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
      n_checks++; if (DROP !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", DROP); end
      RST = 1'b1;
      @(negedge CLK);
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", BUSY); end
   endtask

   task automatic test_single();
      RES_DATA = 16'hA55A; RES_VALID = 1'b1; TX_READY = 1'b1;
      @(negedge CLK); RES_VALID = 1'b0;
      n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL single_latency: got %b expected 0", TX_VALID); end
      n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", BUSY); end
      @(negedge CLK);
      n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h5A) begin n_fail++; $display("FAIL single_b0: got v=%b %h expected v=1 5a", TX_VALID, TX_DATA); end
      @(negedge CLK);
      n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'hA5) begin n_fail++; $display("FAIL single_b1: got v=%b %h expected v=1 a5", TX_VALID, TX_DATA); end
      @(negedge CLK);
      n_checks++; if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL single_idle: got v=%b busy=%b expected 0 0", TX_VALID, BUSY); end
   endtask

   task automatic test_hold();
      RES_DATA = 16'hA55A; RES_VALID = 1'b1; TX_READY = 1'b0;
      @(negedge CLK); RES_VALID = 1'b0;
      @(negedge CLK);
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h5A) begin n_fail++; $display("FAIL hold_%0d: got v=%b %h expected v=1 5a", i, TX_VALID, TX_DATA); end
         @(negedge CLK);
      end
      TX_READY = 1'b1;
      n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h5A) begin n_fail++; $display("FAIL hold_release_b0: got v=%b %h expected v=1 5a", TX_VALID, TX_DATA); end
      @(negedge CLK);
      n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'hA5) begin n_fail++; $display("FAIL hold_release_b1: got v=%b %h expected v=1 a5", TX_VALID, TX_DATA); end
      @(negedge CLK);
      n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL hold_idle: got %b expected 0", TX_VALID); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] words [3];
      logic [7:0]  exp   [6];
      words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
      for (int i = 0; i < 3; i++) begin exp[2*i] = words[i][7:0]; exp[2*i+1] = words[i][15:8]; end
      TX_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         RES_DATA = words[i]; RES_VALID = 1'b1;
         @(negedge CLK);
         n_checks++; if (DROP !== 1'b0) begin n_fail++; $display("FAIL b2b_nodrop_%0d: got %b expected 0", i, DROP); end
      end
      RES_VALID = 1'b0;
      n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h34) begin n_fail++; $display("FAIL b2b_loaded: got v=%b %h expected v=1 34", TX_VALID, TX_DATA); end
      TX_READY = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== exp[i]) begin n_fail++; $display("FAIL b2b_byte_%0d: got v=%b %h expected v=1 %h", i, TX_VALID, TX_DATA, exp[i]); end
         @(negedge CLK);
      end
      n_checks++; if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got v=%b busy=%b expected 0 0", TX_VALID, BUSY); end
   endtask

   task automatic test_drop();
      logic [15:0] words [4];
      logic [7:0]  exp   [6];
      words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC; words[3] = 16'hDEAD;
      for (int i = 0; i < 3; i++) begin exp[2*i] = words[i][7:0]; exp[2*i+1] = words[i][15:8]; end
      TX_READY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         RES_DATA = words[i]; RES_VALID = 1'b1;
         @(negedge CLK);
         n_checks++; if (DROP !== (i == 3)) begin n_fail++; $display("FAIL drop_after_%0d: got %b expected %b", i, DROP, (i == 3)); end
      end
      RES_VALID = 1'b0;
      @(negedge CLK);
      n_checks++; if (DROP !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_width: got %b expected 0", DROP); end
      TX_READY = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== exp[i]) begin n_fail++; $display("FAIL drop_byte_%0d: got v=%b %h expected v=1 %h", i, TX_VALID, TX_DATA, exp[i]); end
         @(negedge CLK);
      end
      n_checks++; if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got v=%b busy=%b expected 0 0", TX_VALID, BUSY); end
   endtask

   task automatic test_reset_mid_word();
      RES_DATA = 16'hA55A; RES_VALID = 1'b1; TX_READY = 1'b1;
      @(negedge CLK); RES_VALID = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'hA5) begin n_fail++; $display("FAIL rstmid_pre: got v=%b %h expected v=1 a5", TX_VALID, TX_DATA); end
      #2 RST = 1'b0;
      #1;
      n_checks++; if (TX_VALID !== 1'b0 || TX_DATA !== 8'h00 || BUSY !== 1'b0 || DROP !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_async: got v=%b d=%h busy=%b drop=%b expected all 0", TX_VALID, TX_DATA, BUSY, DROP);
      end
      @(negedge CLK); RST = 1'b1;
      @(negedge CLK);
      RES_DATA = 16'h00FF; RES_VALID = 1'b1;
      @(negedge CLK); RES_VALID = 1'b0;
      @(negedge CLK);
      n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'hFF) begin n_fail++; $display("FAIL rstmid_b0: got v=%b %h expected v=1 ff", TX_VALID, TX_DATA); end
      @(negedge CLK);
      n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h00) begin n_fail++; $display("FAIL rstmid_b1: got v=%b %h expected v=1 00", TX_VALID, TX_DATA); end
      @(negedge CLK);
      n_checks++; if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got v=%b busy=%b expected 0 0", TX_VALID, BUSY); end
   endtask

   task automatic test_full_pop_push();
      logic [7:0] exp [5];
      exp[0] = 8'h56; exp[1] = 8'hBC; exp[2] = 8'h9A; exp[3] = 8'h21; exp[4] = 8'h43;
      TX_READY = 1'b0;
      RES_DATA = 16'h1234; RES_VALID = 1'b1; @(negedge CLK);
      RES_DATA = 16'h5678; @(negedge CLK);
      RES_DATA = 16'h9ABC; @(negedge CLK);
      RES_VALID = 1'b0; TX_READY = 1'b1;
      @(negedge CLK);
      n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h12 || BUSY !== 1'b1) begin n_fail++; $display("FAIL fpp_last_byte: got v=%b %h busy=%b expected v=1 12 busy=1", TX_VALID, TX_DATA, BUSY); end
      RES_DATA = 16'h4321; RES_VALID = 1'b1;
      @(negedge CLK); RES_VALID = 1'b0;
      n_checks++; if (DROP !== 1'b0) begin n_fail++; $display("FAIL fpp_nodrop: got %b expected 0", DROP); end
      n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h78) begin n_fail++; $display("FAIL fpp_next_low: got v=%b %h expected v=1 78", TX_VALID, TX_DATA); end
      @(negedge CLK);
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== exp[i]) begin n_fail++; $display("FAIL fpp_byte_%0d: got v=%b %h expected v=1 %h", i, TX_VALID, TX_DATA, exp[i]); end
         @(negedge CLK);
      end
      n_checks++; if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL fpp_idle: got v=%b busy=%b expected 0 0", TX_VALID, BUSY); end
   endtask

   task automatic test_random();
      int unsigned errs = 0;
      for (int cyc = 0; cyc < 700; cyc++) begin
         bit draining;
         draining = (cyc >= 640);
         n_checks++;
         if (TX_VALID !== (m_cur.size() > 0) || DROP !== m_drop ||
             BUSY !== ((m_fifo.size() > 0) || (m_cur.size() > 0)) ||
             (m_cur.size() > 0 && TX_DATA !== m_cur[0])) begin
            n_fail++; errs++;
            if (errs <= 10)
               $display("FAIL rand_cyc_%0d: got v=%b d=%h busy=%b drop=%b expected v=%b d=%h busy=%b drop=%b",
                        cyc, TX_VALID, TX_DATA, BUSY, DROP, (m_cur.size() > 0),
                        (m_cur.size() > 0) ? m_cur[0] : 8'h00,
                        ((m_fifo.size() > 0) || (m_cur.size() > 0)), m_drop);
         end
         RES_DATA  = WIDTH'($urandom);
         RES_VALID = !draining && ($urandom_range(0, 99) < 40);
         TX_READY  = draining || ($urandom_range(0, 99) < 60);
         @(negedge CLK);
      end
      n_checks++; if (BUSY !== 1'b0 || TX_VALID !== 1'b0) begin n_fail++; $display("FAIL rand_drained: got busy=%b v=%b expected 0 0", BUSY, TX_VALID); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_hold();
      test_back_to_back();
      test_drop();
      test_reset_mid_word();
      test_full_pop_push();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
